// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a sync_fifo and its user.
// The master drives write/read/flush requests; the slave (the FIFO) returns data and status.
interface sync_fifo_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
);
  logic                    flush;
  logic [DATA_WIDTH-1:0]   write_data;
  logic                    write_increment;
  logic                    read_increment;
  logic [DATA_WIDTH-1:0]   read_data;
  logic                    full;
  logic                    empty;
  logic                    almost_full;
  logic                    almost_empty;
  logic [ADDRESS_WIDTH:0]  count;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output flush, write_data, write_increment, read_increment,
    input  read_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, write_data, write_increment, read_increment,
    output read_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy flags, flush and overflow/underflow pulses; data one cycle after pop,
// or combinational head in show-ahead mode. Writes when full and reads when empty are dropped and flagged.
module sync_fifo #(
  parameter int DATA_WIDTH              = 8,
  parameter int ADDRESS_WIDTH           = 4,
  parameter int ALMOST_FULL_LEVEL       = 12,
  parameter int ALMOST_EMPTY_LEVEL      = 4,
  parameter bit FIRST_WORD_FALL_THROUGH = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  sync_fifo_if.slave fifo
);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  typedef logic [ADDRESS_WIDTH:0] ptr_t;
  localparam ptr_t FULL_COUNT = ptr_t'(DEPTH);
  localparam ptr_t AF_LEVEL   = ptr_t'(ALMOST_FULL_LEVEL);
  localparam ptr_t AE_LEVEL   = ptr_t'(ALMOST_EMPTY_LEVEL);

  if (ALMOST_EMPTY_LEVEL < 0 || ALMOST_EMPTY_LEVEL >= ALMOST_FULL_LEVEL ||
      ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_levels
    $error("sync_fifo: need 0 <= ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL <= DEPTH");
  end

  ptr_t                  wptr_q, wptr_d;
  ptr_t                  rptr_q, rptr_d;
  ptr_t                  count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] head;
  logic                  full, empty, wr_acc, rd_acc;

  assign full   = (count_q == FULL_COUNT);
  assign empty  = (count_q == '0);
  assign wr_acc = fifo.write_increment & ~full  & ~fifo.flush;
  assign rd_acc = fifo.read_increment  & ~empty & ~fifo.flush;
  assign head   = mem_q[rptr_q[ADDRESS_WIDTH-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (fifo.flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + ptr_t'(1);
      if (rd_acc) rptr_d = rptr_q + ptr_t'(1);
    end
    // Extra MSB on the pointers makes the difference span 0..DEPTH without ambiguity.
    count_d = wptr_d - rptr_d;
    ovf_d   = fifo.write_increment & full  & ~fifo.flush;
    unf_d   = fifo.read_increment  & empty & ~fifo.flush;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately left unreset; empty/count gate any stale contents.
  always_ff @(posedge clock) begin
    if (wr_acc) mem_q[wptr_q[ADDRESS_WIDTH-1:0]] <= fifo.write_data;
  end

  if (FIRST_WORD_FALL_THROUGH) begin : g_show_ahead
    assign fifo.read_data = empty ? '0 : head;
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (rd_acc) rdata_d = head;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rdata_q <= '0;
      else          rdata_q <= rdata_d;
    end

    assign fifo.read_data = rdata_q;
  end

  assign fifo.count        = count_q;
  assign fifo.full         = full;
  assign fifo.empty        = empty;
  assign fifo.almost_full  = (count_q >= AF_LEVEL);
  assign fifo.almost_empty = (count_q <= AE_LEVEL);
  assign fifo.overflow     = ovf_q;
  assign fifo.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Drives a registered-read and a show-ahead sync_fifo with identical stimulus and
// compares both against a queue-based model of the FIFO contents after every clock.
module tb_sync_fifo;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int AEL   = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  sync_fifo_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) if_reg ();
  sync_fifo_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) if_fwft ();

  sync_fifo #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALMOST_FULL_LEVEL(AFL),
    .ALMOST_EMPTY_LEVEL(AEL), .FIRST_WORD_FALL_THROUGH(1'b0)
  ) u_reg (.clock(clock), .reset_n(reset_n), .fifo(if_reg));

  sync_fifo #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALMOST_FULL_LEVEL(AFL),
    .ALMOST_EMPTY_LEVEL(AEL), .FIRST_WORD_FALL_THROUGH(1'b1)
  ) u_fwft (.clock(clock), .reset_n(reset_n), .fifo(if_fwft));

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_q [$];
  logic [7:0] exp_rdata;
  logic       exp_ovf;
  logic       exp_unf;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic fl, input logic [7:0] d);
    if_reg.write_increment  = wr;
    if_reg.read_increment   = rd;
    if_reg.flush            = fl;
    if_reg.write_data       = d;
    if_fwft.write_increment = wr;
    if_fwft.read_increment  = rd;
    if_fwft.flush           = fl;
    if_fwft.write_data      = d;
  endtask

  task automatic check_all(input string where);
    int         n    = model_q.size();
    logic [7:0] head = (n == 0) ? 8'h00 : model_q[0];
    chk({where, "/reg.count"},     16'(if_reg.count),         16'(n));
    chk({where, "/reg.full"},      16'(if_reg.full),          16'(n == DEPTH));
    chk({where, "/reg.empty"},     16'(if_reg.empty),         16'(n == 0));
    chk({where, "/reg.afull"},     16'(if_reg.almost_full),   16'(n >= AFL));
    chk({where, "/reg.aempty"},    16'(if_reg.almost_empty),  16'(n <= AEL));
    chk({where, "/reg.overflow"},  16'(if_reg.overflow),      16'(exp_ovf));
    chk({where, "/reg.underflow"}, 16'(if_reg.underflow),     16'(exp_unf));
    chk({where, "/reg.rdata"},     16'(if_reg.read_data),     16'(exp_rdata));
    chk({where, "/fwft.count"},    16'(if_fwft.count),        16'(n));
    chk({where, "/fwft.full"},     16'(if_fwft.full),         16'(n == DEPTH));
    chk({where, "/fwft.empty"},    16'(if_fwft.empty),        16'(n == 0));
    chk({where, "/fwft.afull"},    16'(if_fwft.almost_full),  16'(n >= AFL));
    chk({where, "/fwft.aempty"},   16'(if_fwft.almost_empty), 16'(n <= AEL));
    chk({where, "/fwft.overflow"}, 16'(if_fwft.overflow),     16'(exp_ovf));
    chk({where, "/fwft.underflow"},16'(if_fwft.underflow),    16'(exp_unf));
    chk({where, "/fwft.rdata"},    16'(if_fwft.read_data),    16'(head));
  endtask

  // One clock of stimulus: update the model from the pre-edge occupancy, then check after the edge.
  task automatic cyc(input logic wr, input logic rd, input logic fl, input logic [7:0] d,
                     input string where);
    int n = model_q.size();
    drive(wr, rd, fl, d);
    if (fl) begin
      model_q.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      exp_ovf = wr && (n == DEPTH);
      exp_unf = rd && (n == 0);
      if (rd && n != 0) exp_rdata = model_q.pop_front();
      if (wr && n != DEPTH) model_q.push_back(d);
    end
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check_all(where);
  endtask

  task automatic random_phase(input int cycles, input string where);
    for (int i = 0; i < cycles; i++) begin
      int   bias = ((i / 40) % 2 == 0) ? 3 : 1;
      logic wr   = ($urandom_range(0, 3) < bias);
      logic rd   = ($urandom_range(0, 3) >= bias);
      logic fl   = ($urandom_range(0, 63) == 0);
      cyc(wr, rd, fl, 8'($urandom), where);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    exp_rdata = 8'h00;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check_all("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 8'(i), "fill");
    cyc(1'b1, 1'b0, 1'b0, 8'hEE, "overflow");
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "overflow_clear");

    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00, "drain");
    cyc(1'b0, 1'b1, 1'b0, 8'h00, "underflow");
    chk("underflow_holds_0f", 16'(if_reg.read_data), 16'h000F);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "underflow_clear");

    cyc(1'b1, 1'b1, 1'b0, 8'hA5, "wr_rd_on_empty");
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "fwft_hold");
    chk("fwft_shows_a5", 16'(if_fwft.read_data), 16'h00A5);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, "fwft_pop");

    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom), "to_eight");
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, 8'($urandom), "steady_eight");

    random_phase(400, "random_a");

    while (model_q.size() < DEPTH) cyc(1'b1, 1'b0, 1'b0, 8'($urandom), "refill");
    cyc(1'b1, 1'b1, 1'b1, 8'h77, "flush_full");
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "post_flush");

    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom), "pre_reset");
    #3 reset_n = 1'b0;
    #1;
    model_q.delete();
    exp_rdata = 8'h00;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    check_all("async_reset");
    repeat (2) @(negedge clock);
    check_all("reset_held");
    reset_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 8'h3C, "post_reset_wr");
    cyc(1'b0, 1'b1, 1'b0, 8'h00, "post_reset_rd");
    chk("post_reset_rdata_3c", 16'(if_reg.read_data), 16'h003C);

    random_phase(400, "random_b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
